// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks a combinational-read instruction memory,
// presents fetched words over a valid/ready handshake, and honours redirects.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 88
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] inst_address,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_inst_d    = out_inst_q;
    out_pc_d      = out_pc_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = RUN;
        end
      end

      RUN, HALT: begin
        // A redirect flushes the held word even if the consumer accepts it this cycle.
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d = FAULT;
          end else if (redirect_pc > LAST_PC) begin
            pc_d    = redirect_pc;
            state_d = HALT;
          end else begin
            pc_d    = redirect_pc;
            state_d = RUN;
          end
        end else if (state_q == RUN && (!out_valid_q || out_ready)) begin
          out_inst_d    = instruction;
          out_pc_d      = pc_q;
          out_valid_d   = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
          pc_d          = pc_q + 32'd4;
          if (pc_q >= LAST_PC) begin
            state_d = HALT;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      FAULT: begin
        out_valid_d = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_inst_q    <= 32'h0;
      out_pc_q      <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_inst_q    <= out_inst_d;
      out_pc_q      <= out_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign inst_address = pc_q;
  assign out_valid    = out_valid_q;
  assign out_inst     = out_inst_q;
  assign out_pc       = out_pc_q;
  assign fetch_count  = fetch_count_q;
  assign halted       = (state_q == HALT);
  assign fault        = (state_q == FAULT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed testbench for imem_fetch_ctrl with a small combinational memory model.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] inst_address;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  int tests_run;
  int tests_failed;

  imem_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(88)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .inst_address  (inst_address),
    .instruction   (instruction),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .halted        (halted),
    .fault         (fault),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed word at address 0, an address-tagged word elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)
      return 32'h0000_0913;
    else if (a > 32'h54)
      return 32'hDEAD_BEEF;
    else
      return {16'hC0DE, a[15:0]};
  endfunction

  always_comb instruction = mem_word(inst_address);

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic start_run();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    logic [98:0] got;
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    #3;
    got = {out_valid, out_inst, out_pc, fetch_count, halted, fault};
    tests_run++;
    if (got !== 99'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", got);
    end
    tests_run++;
    if (inst_address !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pc: got %h expected 00000000", inst_address);
    end
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    tests_run++;
    if ({out_valid, halted, fault, fetch_count, inst_address} !== 67'h0) begin
      tests_failed++;
      $display("[TB] FAIL idle_wait: valid=%b halted=%b fault=%b count=%0d addr=%h expected all zero",
               out_valid, halted, fault, fetch_count, inst_address);
    end
  endtask

  task automatic test_first_fetch();
    start_run();
    tests_run++;
    if (out_valid !== 1'b0 || inst_address !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL first_present: valid=%b addr=%h expected 0/00000000", out_valid, inst_address);
    end
    cycle();
    tests_run++;
    if ({out_valid, out_pc, out_inst, fetch_count} !== {1'b1, 32'h0, 32'h0000_0913, 32'd1}) begin
      tests_failed++;
      $display("[TB] FAIL first_capture: valid=%b pc=%h inst=%h count=%0d expected 1/00000000/00000913/1",
               out_valid, out_pc, out_inst, fetch_count);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    start = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      cycle();
      exp_pc = 32'(4 * i);
      tests_run++;
      if ({out_valid, out_pc, out_inst, fetch_count, halted} !==
          {1'b1, exp_pc, mem_word(exp_pc), 32'(i + 1), (i == 21)}) begin
        tests_failed++;
        $display("[TB] FAIL free_run_%0d: valid=%b pc=%h inst=%h count=%0d halted=%b expected pc=%h count=%0d",
                 i, out_valid, out_pc, out_inst, fetch_count, halted, exp_pc, i + 1);
      end
    end
    start = 1'b0;
    cycle();
    tests_run++;
    if ({out_valid, halted, fetch_count} !== {1'b0, 1'b1, 32'd22}) begin
      tests_failed++;
      $display("[TB] FAIL halt_accept: valid=%b halted=%b count=%0d expected 0/1/22",
               out_valid, halted, fetch_count);
    end
    cycle();
    tests_run++;
    if ({out_valid, halted, fetch_count, inst_address} !== {1'b0, 1'b1, 32'd22, 32'h58}) begin
      tests_failed++;
      $display("[TB] FAIL halt_stays: valid=%b halted=%b count=%0d addr=%h expected 0/1/22/00000058",
               out_valid, halted, fetch_count, inst_address);
    end
  endtask

  task automatic test_back_pressure();
    pulse_reset();
    out_ready = 1'b1;
    start_run();
    repeat (5) cycle();
    tests_run++;
    if ({out_valid, out_pc, fetch_count} !== {1'b1, 32'h10, 32'd5}) begin
      tests_failed++;
      $display("[TB] FAIL bp_reach: valid=%b pc=%h count=%0d expected 1/00000010/5", out_valid, out_pc, fetch_count);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests_run++;
      if ({out_valid, out_pc, out_inst, inst_address, fetch_count} !==
          {1'b1, 32'h10, mem_word(32'h10), 32'h14, 32'd5}) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_%0d: valid=%b pc=%h inst=%h addr=%h count=%0d expected 1/00000010/%h/00000014/5",
                 k, out_valid, out_pc, out_inst, inst_address, fetch_count, mem_word(32'h10));
      end
    end
    out_ready = 1'b1;
    cycle();
    tests_run++;
    if ({out_valid, out_pc, fetch_count} !== {1'b1, 32'h14, 32'd6}) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: valid=%b pc=%h count=%0d expected 1/00000014/6", out_valid, out_pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    repeat (8) cycle();
    tests_run++;
    if ({out_valid, out_pc, fetch_count} !== {1'b1, 32'h34, 32'd14}) begin
      tests_failed++;
      $display("[TB] FAIL redir_reach: valid=%b pc=%h count=%0d expected 1/00000034/14", out_valid, out_pc, fetch_count);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    cycle();
    redirect_valid = 1'b0;
    tests_run++;
    if ({out_valid, fetch_count, inst_address, halted} !== {1'b0, 32'd14, 32'h20, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL redir_flush: valid=%b count=%0d addr=%h halted=%b expected 0/14/00000020/0",
               out_valid, fetch_count, inst_address, halted);
    end
    cycle();
    tests_run++;
    if ({out_valid, out_pc, out_inst, fetch_count} !== {1'b1, 32'h20, mem_word(32'h20), 32'd15}) begin
      tests_failed++;
      $display("[TB] FAIL redir_target: valid=%b pc=%h inst=%h count=%0d expected 1/00000020/%h/15",
               out_valid, out_pc, out_inst, fetch_count, mem_word(32'h20));
    end
  endtask

  task automatic test_redirect_bounds();
    redirect_valid = 1'b1;
    redirect_pc = 32'h60;
    cycle();
    tests_run++;
    if ({out_valid, halted, inst_address, fetch_count} !== {1'b0, 1'b1, 32'h60, 32'd15}) begin
      tests_failed++;
      $display("[TB] FAIL redir_beyond: valid=%b halted=%b addr=%h count=%0d expected 0/1/00000060/15",
               out_valid, halted, inst_address, fetch_count);
    end
    redirect_pc = 32'h50;
    cycle();
    redirect_valid = 1'b0;
    tests_run++;
    if ({out_valid, halted, inst_address} !== {1'b0, 1'b0, 32'h50}) begin
      tests_failed++;
      $display("[TB] FAIL redir_from_halt: valid=%b halted=%b addr=%h expected 0/0/00000050",
               out_valid, halted, inst_address);
    end
    cycle();
    tests_run++;
    if ({out_valid, out_pc, fetch_count, halted} !== {1'b1, 32'h50, 32'd16, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL near_end_capture: valid=%b pc=%h count=%0d halted=%b expected 1/00000050/16/0",
               out_valid, out_pc, fetch_count, halted);
    end
    cycle();
    tests_run++;
    if ({out_valid, out_pc, fetch_count, halted} !== {1'b1, 32'h54, 32'd17, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL last_capture: valid=%b pc=%h count=%0d halted=%b expected 1/00000054/17/1",
               out_valid, out_pc, fetch_count, halted);
    end
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    cycle();
    tests_run++;
    if ({fault, halted, out_valid, fetch_count} !== {1'b1, 1'b0, 1'b0, 32'd17}) begin
      tests_failed++;
      $display("[TB] FAIL fault_enter: fault=%b halted=%b valid=%b count=%0d expected 1/0/0/17",
               fault, halted, out_valid, fetch_count);
    end
    start = 1'b1;
    redirect_pc = 32'h20;
    repeat (2) cycle();
    start = 1'b0;
    redirect_valid = 1'b0;
    tests_run++;
    if ({fault, out_valid, fetch_count} !== {1'b1, 1'b0, 32'd17}) begin
      tests_failed++;
      $display("[TB] FAIL fault_sticky: fault=%b valid=%b count=%0d expected 1/0/17", fault, out_valid, fetch_count);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({fault, halted, out_valid, fetch_count, inst_address} !== 67'h0) begin
      tests_failed++;
      $display("[TB] FAIL fault_reset: fault=%b halted=%b valid=%b count=%0d addr=%h expected all zero",
               fault, halted, out_valid, fetch_count, inst_address);
    end
    cycle();
    rst_n = 1'b1;
    repeat (2) cycle();
    tests_run++;
    if ({fault, halted, out_valid, fetch_count} !== 35'h0) begin
      tests_failed++;
      $display("[TB] FAIL fault_to_idle: fault=%b halted=%b valid=%b count=%0d expected all zero",
               fault, halted, out_valid, fetch_count);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    start_run();
    repeat (2) cycle();
    tests_run++;
    if ({out_valid, out_pc, fetch_count} !== {1'b1, 32'h4, 32'd2}) begin
      tests_failed++;
      $display("[TB] FAIL async_setup: valid=%b pc=%h count=%0d expected 1/00000004/2", out_valid, out_pc, fetch_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_inst, out_pc, fetch_count, halted, fault, inst_address} !== 131'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: valid=%b inst=%h pc=%h count=%0d halted=%b fault=%b addr=%h expected all zero",
               out_valid, out_inst, out_pc, fetch_count, halted, fault, inst_address);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_first_fetch();
    test_free_run();
    test_back_pressure();
    test_redirect();
    test_redirect_bounds();
    test_fault();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
